// File: rtl/xbox_mem_arb_if.sv
// ---------------------------------------------------------------------------
// xbox_mem_arb_if
// Bundles the per-master request side and the shared memory side of the
// xbox_mem_arb round-robin arbiter.
//   req_addr/req_wdata/req_be  per-master access payload
//   req_rd/req_wr/req_lock     per-master level requests, held until granted
//   req_gnt/req_rvalid         one-hot grant and read-return strobes
//   req_rdata                  read data broadcast to all masters
//   mem_*                      single port towards the shared memory
// Modports:
//   slave  - the arbiter's view (consumes requests, drives grants and memory)
//   master - the environment's view (masters plus the memory model)
// ---------------------------------------------------------------------------
interface xbox_mem_arb_if #(
    parameter int NUM_REQ            = 2,
    parameter int LOG2_LINES_PER_MEM = 4
);
    logic [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0] req_addr;
    logic [NUM_REQ-1:0][7:0][31:0]              req_wdata;
    logic [NUM_REQ-1:0][31:0]                   req_be;
    logic [NUM_REQ-1:0]                         req_rd;
    logic [NUM_REQ-1:0]                         req_wr;
    logic [NUM_REQ-1:0]                         req_lock;
    logic [NUM_REQ-1:0]                         req_gnt;
    logic [NUM_REQ-1:0]                         req_rvalid;
    logic [7:0][31:0]                           req_rdata;
    logic [LOG2_LINES_PER_MEM-1:0]              mem_addr;
    logic [7:0][31:0]                           mem_wdata;
    logic [31:0]                                mem_be;
    logic                                       mem_rd;
    logic                                       mem_wr;
    logic [7:0][31:0]                           mem_rdata;

    modport slave (
        input  req_addr, req_wdata, req_be, req_rd, req_wr, req_lock, mem_rdata,
        output req_gnt, req_rvalid, req_rdata,
        output mem_addr, mem_wdata, mem_be, mem_rd, mem_wr
    );

    modport master (
        output req_addr, req_wdata, req_be, req_rd, req_wr, req_lock, mem_rdata,
        input  req_gnt, req_rvalid, req_rdata,
        input  mem_addr, mem_wdata, mem_be, mem_rd, mem_wr
    );
endinterface

// File: rtl/xbox_mem_arb.sv
// ---------------------------------------------------------------------------
// xbox_mem_arb
// Round-robin arbiter sharing one memory port between NUM_REQ masters.
// At most one access is granted per cycle (combinational grant, the access
// executes in the grant cycle); read data is routed back to the reader one
// cycle later. A master may lock the port; a watchdog forces the release
// after MAX_LOCK cycles in the locked state.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           request + memory signals (xbox_mem_arb_if.slave)
//   lock_timeout  one-cycle pulse on the cycle a lock is forcibly released
//   gnt_cnt       per-master saturating grant counters
// ---------------------------------------------------------------------------
module xbox_mem_arb #(
    parameter int NUM_REQ            = 2,
    parameter int LOG2_LINES_PER_MEM = 4,
    parameter int MAX_LOCK           = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    xbox_mem_arb_if.slave             bus,
    output logic                      lock_timeout,
    output logic [NUM_REQ-1:0][15:0]  gnt_cnt
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t         state_reg;
    logic [IW-1:0]  ptr_reg;
    logic [IW-1:0]  owner_reg;
    logic [15:0]    lock_cnt_reg;
    logic [IW-1:0]  rd_owner_reg;
    logic           rd_valid_reg;
    logic [15:0]    cnt_reg [NUM_REQ];

    logic [NUM_REQ-1:0] active;
    logic [IW-1:0]      win;
    logic               win_found;
    logic [IW-1:0]      sel;
    logic               granted;
    logic               owner_lock;
    logic               timeout_hit;

    // Modulo-NUM_REQ increment without a divider (NUM_REQ need not be a power of 2).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
    endfunction

    assign active = bus.req_rd | bus.req_wr;

    // Rotating priority search starting at ptr_reg.
    always_comb begin
        logic [IW-1:0] cand;
        win       = '0;
        win_found = 1'b0;
        cand      = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && active[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    assign sel         = (state_reg == LOCKED) ? owner_reg : win;
    assign granted     = !rst && ((state_reg == LOCKED) ? active[owner_reg] : win_found);
    assign owner_lock  = bus.req_lock[owner_reg];
    // Forced release only when the owner still wants the lock at the last allowed cycle.
    assign timeout_hit = (state_reg == LOCKED) && owner_lock &&
                         (lock_cnt_reg == 16'(MAX_LOCK - 1));
    assign lock_timeout = !rst && timeout_hit;

    // Memory port is a straight pass-through from the selected master.
    // A combined rd+wr request is executed as a write only.
    always_comb begin
        bus.req_gnt = '0;
        if (granted) begin
            bus.req_gnt[sel] = 1'b1;
        end
        bus.mem_addr  = bus.req_addr[sel];
        bus.mem_wdata = bus.req_wdata[sel];
        bus.mem_be    = granted ? bus.req_be[sel] : '0;
        bus.mem_wr    = granted & bus.req_wr[sel];
        bus.mem_rd    = granted & bus.req_rd[sel] & ~bus.req_wr[sel];
    end

    assign bus.req_rdata = bus.mem_rdata;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_per_master
            assign bus.req_rvalid[gi] = !rst && rd_valid_reg && (rd_owner_reg == IW'(gi));
            assign gnt_cnt[gi]        = cnt_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (bus.req_gnt[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            lock_cnt_reg <= '0;
            rd_owner_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.mem_rd;
            rd_owner_reg <= sel;
            if (state_reg == ARB) begin
                if (granted) begin
                    ptr_reg <= wrap_inc(win);
                    if (bus.req_lock[win]) begin
                        state_reg    <= LOCKED;
                        owner_reg    <= win;
                        lock_cnt_reg <= '0;
                    end
                end
            end else begin
                // Owner dropping the lock releases even if it is accessing this cycle.
                if (!owner_lock || timeout_hit) begin
                    state_reg    <= ARB;
                    ptr_reg      <= wrap_inc(owner_reg);
                    lock_cnt_reg <= '0;
                end else begin
                    lock_cnt_reg <= lock_cnt_reg + 16'd1;
                end
            end
        end
    end
endmodule

// File: doc/xbox_mem_arb.md
Name: xbox_mem_arb

Overview:
- Round-robin arbiter that shares one XBOX-mastered memory instance between NUM_REQ accelerator masters. Examples of masters: multiple MatMul engines, or a MatMul engine plus a copy engine.
- Sits between the masters and one instance of the xlr_mem_* interface.
- Grants at most one access per cycle and routes read data back to the granted reader one cycle later.
- Supports a lock, so one master can own the port for multi-cycle sequences such as read, compute, write-back. A lock timeout watchdog bounds how long the port can be held.

Parameters:
- NUM_REQ, 2: number of requesting masters; legal range 2..8.
- LOG2_LINES_PER_MEM, 4: address width of the shared memory.
- MAX_LOCK, 64: longest lock hold in cycles before a forced release; legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_addr  in  [NUM_REQ][LOG2_LINES_PER_MEM]  per-master line address
- req_wdata  in  [NUM_REQ][8][32]  per-master write data
- req_be  in  [NUM_REQ][32]  per-master byte enables
- req_rd  in  [NUM_REQ]  read request, level, held until granted
- req_wr  in  [NUM_REQ]  write request, level, held until granted
- req_lock  in  [NUM_REQ]  request or keep exclusive ownership
- req_gnt  out  [NUM_REQ]  one-hot grant; the access executes in this cycle
- req_rvalid  out  [NUM_REQ]  one-hot; req_rdata is valid for the indicated master
- req_rdata  out  [8][32]  read data, broadcast to all masters
- mem_addr  out  LOG2_LINES_PER_MEM  to memory
- mem_wdata  out  [8][32]  to memory
- mem_be  out  32  to memory
- mem_rd  out  1  to memory
- mem_wr  out  1  to memory
- mem_rdata  in  [8][32]  from memory, valid one cycle after mem_rd
- lock_timeout  out  1  single-cycle pulse when a lock is forcibly released
- gnt_cnt  out  [NUM_REQ][16]  grants per master; saturating at 16'hFFFF

Behaviour:
- Registered state:
  - ptr: round-robin pointer, reset 0.
  - state: ARB or LOCKED, reset ARB.
  - owner: reset 0.
  - lock_cnt: reset 0.
  - rd_owner_q / rd_valid_q: read-return pipeline, reset 0.
  - gnt_cnt: reset 0.
- Reset values of outputs:
  - While rst=1: req_gnt, mem_rd, mem_wr, mem_be, req_rvalid and lock_timeout are all 0.
  - mem_addr, mem_wdata and req_rdata are don't-care during reset.
- Active master: master i is active when req_rd[i] | req_wr[i].
- ARB state:
  - The winner is the first active master searching i = ptr, ptr+1, ... modulo NUM_REQ.
  - The grant is combinational, so it is seen in the same cycle as the request.
  - If no master is active, there is no grant and ptr holds.
- On a grant to master w:
  - The memory port is driven from master w: addr, wdata, be, rd and wr pass through unchanged.
  - ptr is set to (w+1) mod NUM_REQ at the next clock.
- Entering LOCKED:
  - If the winner has req_lock[w]=1 on the granted cycle, the next state is LOCKED with owner=w and lock_cnt=0.
- LOCKED state:
  - Only the owner can be granted; it is granted whenever it is active. All other masters wait.
  - lock_cnt increments every cycle.
- Leaving LOCKED (return to ARB next cycle):
  - The owner's req_lock=0, with or without an access. A granted access on that cycle still executes.
  - Or lock_cnt reaches MAX_LOCK-1. In this case lock_timeout pulses for 1 cycle, and the owner's access on that cycle is still granted.
  - ptr becomes owner+1 on release.
- Single-master rotation:
  - A lone active master is granted every cycle in ARB. ptr still advances past it each time.
- Both rd and wr asserted by one master:
  - The access is granted as a write (mem_rd=0).
  - No read return is produced for it.
- Read return:
  - mem_rd granted at cycle N gives req_rvalid[w]=1 at cycle N+1.
  - req_rdata equals mem_rdata at cycle N+1.
  - Back-to-back reads by different masters return in grant order, one per cycle.
- Grant counter: gnt_cnt[i] increments on every cycle where req_gnt[i]=1, saturating at 16'hFFFF.
- Reset mid-operation:
  - A pending read return is dropped: rvalid is 0 on the next cycle.
  - The lock is cleared, state goes to ARB, ptr goes to 0.
- Invariant: req_gnt is one-hot-or-zero, and mem_rd|mem_wr implies exactly one grant.

Test Plan:
- Reset, then master 0 reads addr 0 with mem_rdata=256'hA5…A5 → req_gnt=2'b01 in the same cycle, req_rvalid=2'b01 with data A5…A5 the next cycle, gnt_cnt[0]=1.
- Masters 0 and 1 hold req_wr for 4 cycles, NUM_REQ=2 → grants alternate 01,10,01,10; mem_addr follows the owner; gnt_cnt={2,2}.
- Master 1 reads with lock=1, then writes addr 1 with lock=0 three cycles later, while master 0 requests continuously → master 0 gets no grant until the cycle after master 1's write; master 0 is then granted.
- Master 0 holds lock=1 for 70 cycles, MAX_LOCK=64 → lock_timeout pulses at cycle 63 of LOCKED; master 1 is granted the following cycle.
- Master 0 asserts rd and wr together to addr 3, be=32'hFFFF_FFFF → mem_wr=1, mem_rd=0, no rvalid.
- Assert rst the cycle after a granted read → req_rvalid=0, state ARB, next grant searches from master 0.
